// File: rtl/sram_pkg.sv
// Shared types for the SRAM arbiter: the lock FSM state and the per-requester access bundle.
package sram_pkg;
  localparam int SRAM_ARB_MAX_REQ = 8;
  localparam int SRAM_ADDR_WIDTH  = 32;
  localparam int SRAM_DATA_WIDTH  = 32;
  localparam int SRAM_STRB_WIDTH  = SRAM_DATA_WIDTH / 8;

  typedef enum logic {IDLE, LOCKED} sram_arb_state_e;

  typedef struct packed {
    logic                       we;
    logic [SRAM_ADDR_WIDTH-1:0] addr;
    logic [SRAM_DATA_WIDTH-1:0] wdata;
    logic [SRAM_STRB_WIDTH-1:0] wstrb;
  } sram_req_t;
endpackage

// File: rtl/sram_if.sv
// Single-port SRAM macro port; controls are active-low, read data arrives one cycle after en_i.
interface sram_if import sram_pkg::*; #(
  parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = SRAM_DATA_WIDTH
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                  clk_i;
  logic                  en_i;
  logic                  wen_i;
  logic [STRB_WIDTH-1:0] bm_i;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [DATA_WIDTH-1:0] dat_i;
  logic [DATA_WIDTH-1:0] dat_o;

  modport master (output clk_i, en_i, wen_i, bm_i, addr_i, dat_i, input dat_o);
  modport slave  (input clk_i, en_i, wen_i, bm_i, addr_i, dat_i, output dat_o);
endinterface

// File: rtl/dffer.sv
// Load-enabled register with synchronous active-high reset to zero.
module dffer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (en) q <= d;
  end
endmodule

// File: rtl/dffr.sv
// Register with synchronous active-high reset to zero.
module dffr #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else     q <= d;
  end
endmodule

// File: rtl/rr_arb.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping; zero latency.
module rr_arb #(
  parameter int NUM_REQ = 2,
  parameter int PW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PW-1:0]      idx
);
  always_comb begin
    int   k;
    logic found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = int'(ptr) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!found && req[k]) begin
        found  = 1'b1;
        gnt[k] = 1'b1;
        idx    = PW'(k);
      end
    end
  end
endmodule

// File: rtl/sram_arb.sv
// Round-robin share of one SRAM macro; grant is combinational, rvalid one cycle after a read grant.
// No backpressure on read data. Define SRAM_ARB_LOCK_EN for lock_i and burst ownership.
module sram_arb import sram_pkg::*; #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                                aclk_i,
  input  logic                                areset_i,
  input  logic [NUM_REQ-1:0]                  req_i,
  input  logic [NUM_REQ-1:0]                  we_i,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  addr_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  wdata_i,
  input  logic [NUM_REQ-1:0][STRB_WIDTH-1:0]  wstrb_i,
`ifdef SRAM_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]                  lock_i,
`endif
  output logic [NUM_REQ-1:0]                  gnt_o,
  output logic [NUM_REQ-1:0]                  rvalid_o,
  output logic [DATA_WIDTH-1:0]               rdata_o,
  sram_if.master                              sram
);
  localparam int PW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] act_req, elig, gnt, rvalid_q;
  logic [PW-1:0]      win, ptr_q, ptr_d;
  logic               any_gnt;
  sram_req_t          reqs [NUM_REQ];
  sram_req_t          sel;

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      reqs[k].we    = we_i[k];
      reqs[k].addr  = SRAM_ADDR_WIDTH'(addr_i[k]);
      reqs[k].wdata = SRAM_DATA_WIDTH'(wdata_i[k]);
      reqs[k].wstrb = SRAM_STRB_WIDTH'(wstrb_i[k]);
    end
  end

  assign act_req = req_i & {NUM_REQ{~areset_i}};

`ifdef SRAM_ARB_LOCK_EN
  sram_arb_state_e    state_q, state_d;
  logic               state_bit_q;
  logic [PW-1:0]      owner_q;
  logic               owner_en;
  logic [NUM_REQ-1:0] own_mask;

  dffr  #(.W(1))  u_state (.clk(aclk_i), .rst(areset_i), .d(state_d), .q(state_bit_q));
  dffer #(.W(PW)) u_owner (.clk(aclk_i), .rst(areset_i), .en(owner_en), .d(win), .q(owner_q));

  assign state_q = sram_arb_state_e'(state_bit_q);

  always_comb begin
    own_mask          = '0;
    own_mask[owner_q] = 1'b1;
    elig              = (state_q == LOCKED) ? (act_req & own_mask) : act_req;
  end

  // A locked owner that drops its request gives up the macro; others get it next cycle.
  always_comb begin
    state_d  = state_q;
    owner_en = 1'b0;
    if (state_q == IDLE) begin
      if (any_gnt && lock_i[win]) begin
        state_d  = LOCKED;
        owner_en = 1'b1;
      end
    end else begin
      if (!req_i[owner_q] || (any_gnt && !lock_i[win])) state_d = IDLE;
    end
  end
`else
  assign elig = act_req;
`endif

  rr_arb #(.NUM_REQ(NUM_REQ), .PW(PW)) u_rr (
    .req (elig),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (win)
  );

  assign any_gnt = |gnt;
  assign gnt_o   = gnt;
  assign sel     = reqs[win];
  assign ptr_d   = (win == PW'(NUM_REQ - 1)) ? '0 : win + PW'(1);

  dffer #(.W(PW))      u_ptr    (.clk(aclk_i), .rst(areset_i), .en(any_gnt), .d(ptr_d), .q(ptr_q));
  dffr  #(.W(NUM_REQ)) u_rvalid (.clk(aclk_i), .rst(areset_i), .d(gnt & ~we_i), .q(rvalid_q));

  // A read granted just before reset must not surface while reset is held.
  assign rvalid_o = rvalid_q & {NUM_REQ{~areset_i}};
  assign rdata_o  = sram.dat_o;

  assign sram.clk_i  = aclk_i;
  assign sram.en_i   = ~any_gnt;
  assign sram.wen_i  = ~(any_gnt & sel.we);
  assign sram.bm_i   = (any_gnt && sel.we) ? STRB_WIDTH'(~sel.wstrb) : '1;
  assign sram.addr_i = any_gnt ? ADDR_WIDTH'(sel.addr) : '0;
  assign sram.dat_i  = any_gnt ? DATA_WIDTH'(sel.wdata) : '0;
endmodule

// File: tb/tb_sram_arb.sv
// Directed bench for sram_arb with a behavioural one-cycle-latency SRAM model.
module tb_sram_arb;
  logic             clk;
  logic             areset;
  logic [1:0]       req, we, lock;
  logic [1:0][31:0] addr, wdata;
  logic [1:0][3:0]  wstrb;
  logic [1:0]       gnt, rvalid;
  logic [31:0]      rdata;
  logic [31:0]      mem [0:255];
  int               checks = 0;
  int               errors = 0;

  sram_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) sif ();

  sram_arb #(.NUM_REQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .aclk_i   (clk),
    .areset_i (areset),
    .req_i    (req),
    .we_i     (we),
    .addr_i   (addr),
    .wdata_i  (wdata),
    .wstrb_i  (wstrb),
`ifdef SRAM_ARB_LOCK_EN
    .lock_i   (lock),
`endif
    .gnt_o    (gnt),
    .rvalid_o (rvalid),
    .rdata_o  (rdata),
    .sram     (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge sif.clk_i) begin
    if (!sif.en_i) begin
      if (!sif.wen_i) begin
        for (int b = 0; b < 4; b++)
          if (!sif.bm_i[b]) mem[sif.addr_i[7:0]][8*b +: 8] <= sif.dat_i[8*b +: 8];
      end else begin
        sif.dat_o <= mem[sif.addr_i[7:0]];
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | 32'(i);
    sif.dat_o = '0;
    areset = 1'b1; req = '0; we = '0; lock = '0;
    addr = '0; wdata = '0; wstrb = '0;

    cyc(); cyc(); #1;
    chk("rst_gnt", 64'(gnt), 64'h0);
    chk("rst_en", 64'(sif.en_i), 64'h1);
    chk("rst_rvalid", 64'(rvalid), 64'h0);
    req = 2'b11; addr[0] = 32'h20; addr[1] = 32'h21; #1;
    chk("rst_gnt_suppressed", 64'(gnt), 64'h0);
    chk("rst_en_with_req", 64'(sif.en_i), 64'h1);

    // Both requesters reading: grants alternate starting at 0
    cyc(); areset = 1'b0; #1;
    chk("rr0_gnt", 64'(gnt), 64'h1);
    chk("rr0_en", 64'(sif.en_i), 64'h0);
    chk("rr0_wen", 64'(sif.wen_i), 64'h1);
    chk("rr0_addr", 64'(sif.addr_i), 64'h20);
    chk("rr0_bm", 64'(sif.bm_i), 64'hF);
    cyc(); #1;
    chk("rr1_gnt", 64'(gnt), 64'h2);
    chk("rr1_addr", 64'(sif.addr_i), 64'h21);
    chk("rr1_rvalid", 64'(rvalid), 64'h1);
    chk("rr1_rdata", 64'(rdata), 64'hA500_0020);
    cyc(); #1;
    chk("rr2_gnt", 64'(gnt), 64'h1);
    chk("rr2_rvalid", 64'(rvalid), 64'h2);
    chk("rr2_rdata", 64'(rdata), 64'hA500_0021);
    cyc(); #1;
    chk("rr3_gnt", 64'(gnt), 64'h2);
    chk("rr3_rvalid", 64'(rvalid), 64'h1);
    chk("rr3_rdata", 64'(rdata), 64'hA500_0020);
    cyc(); req = 2'b00; #1;
    chk("idle_gnt", 64'(gnt), 64'h0);
    chk("idle_en", 64'(sif.en_i), 64'h1);
    chk("idle_wen", 64'(sif.wen_i), 64'h1);
    chk("idle_bm", 64'(sif.bm_i), 64'hF);
    chk("idle_addr", 64'(sif.addr_i), 64'h0);
    chk("idle_rvalid", 64'(rvalid), 64'h2);
    chk("idle_rdata", 64'(rdata), 64'hA500_0021);
    cyc(); #1;
    chk("idle2_rvalid", 64'(rvalid), 64'h0);

    // Partial-strobe write then read-after-write
    req = 2'b01; we[0] = 1'b1; addr[0] = 32'h10; wdata[0] = 32'hDEAD_BEEF; wstrb[0] = 4'b0011; #1;
    chk("wr_gnt", 64'(gnt), 64'h1);
    chk("wr_wen", 64'(sif.wen_i), 64'h0);
    chk("wr_bm", 64'(sif.bm_i), 64'hC);
    chk("wr_dat", 64'(sif.dat_i), 64'hDEAD_BEEF);
    cyc(); we[0] = 1'b0; #1;
    chk("raw_gnt", 64'(gnt), 64'h1);
    chk("raw_wr_no_rvalid", 64'(rvalid), 64'h0);
    chk("raw_bm", 64'(sif.bm_i), 64'hF);
    cyc(); req = 2'b00; #1;
    chk("raw_rvalid", 64'(rvalid), 64'h1);
    chk("raw_rdata", 64'(rdata), 64'hA500_BEEF);

    // Lone requester 1 is granted every cycle regardless of the pointer
    cyc(); req = 2'b10; we[1] = 1'b0; addr[1] = 32'h30; #1;
    chk("solo_gnt_first", 64'(gnt), 64'h2);
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      chk($sformatf("solo_gnt_%0d", i), 64'(gnt), 64'h2);
      chk($sformatf("solo_rvalid_%0d", i), 64'(rvalid), 64'h2);
      chk($sformatf("solo_rdata_%0d", i), 64'(rdata), 64'hA500_0030);
    end

    // Zero-strobe write is granted but leaves memory alone
    cyc(); we[1] = 1'b1; wdata[1] = 32'hFFFF_FFFF; wstrb[1] = 4'b0000; #1;
    chk("zs_gnt", 64'(gnt), 64'h2);
    chk("zs_wen", 64'(sif.wen_i), 64'h0);
    chk("zs_bm", 64'(sif.bm_i), 64'hF);
    cyc(); we[1] = 1'b0; #1;
    chk("zs_rd_gnt", 64'(gnt), 64'h2);
    cyc(); req = 2'b00; #1;
    chk("zs_rvalid", 64'(rvalid), 64'h2);
    chk("zs_rdata", 64'(rdata), 64'hA500_0030);

    // Reset right after a read grant: no rvalid, pointer back to 0
    cyc(); req = 2'b01; addr[0] = 32'h20; #1;
    chk("mid_gnt", 64'(gnt), 64'h1);
    cyc(); areset = 1'b1; req = 2'b11; #1;
    chk("mid_rst_rvalid", 64'(rvalid), 64'h0);
    chk("mid_rst_gnt", 64'(gnt), 64'h0);
    chk("mid_rst_en", 64'(sif.en_i), 64'h1);
    cyc(); areset = 1'b0; #1;
    chk("mid_rst_ptr0", 64'(gnt), 64'h1);
    chk("mid_rst_rvalid_after", 64'(rvalid), 64'h0);

`ifdef SRAM_ARB_LOCK_EN
    cyc(); areset = 1'b1; req = 2'b00; #1;
    cyc(); areset = 1'b0; req = 2'b11; lock = 2'b01; #1;
    chk("lock_gnt_0", 64'(gnt), 64'h1);
    cyc(); #1;
    chk("lock_gnt_1", 64'(gnt), 64'h1);
    cyc(); #1;
    chk("lock_gnt_2", 64'(gnt), 64'h1);
    cyc(); lock = 2'b00; #1;
    chk("lock_gnt_3", 64'(gnt), 64'h1);
    cyc(); req = 2'b10; #1;
    chk("lock_release_gnt", 64'(gnt), 64'h2);
    cyc(); req = 2'b11; lock = 2'b01; #1;
    chk("abandon_lock_gnt", 64'(gnt), 64'h1);
    cyc(); req = 2'b10; #1;
    chk("abandon_wait", 64'(gnt), 64'h0);
    cyc(); #1;
    chk("abandon_gnt", 64'(gnt), 64'h2);
    cyc(); req = 2'b00; lock = 2'b00;
`endif

    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
